// File: rtl/tone_sequencer_pkg.sv
// Shared types and note-frequency constants for the tone sequencer.
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP,
    DONE
  } state_e;

  typedef struct packed {
    logic [31:0] freq;
    logic [15:0] dur;
  } note_t;

  localparam logic [31:0] C4 = 32'd262;
  localparam logic [31:0] D4 = 32'd294;
  localparam logic [31:0] E4 = 32'd330;
  localparam logic [31:0] F4 = 32'd349;
  localparam logic [31:0] G4 = 32'd392;
  localparam logic [31:0] A4 = 32'd440;
  localparam logic [31:0] B4 = 32'd494;
  localparam logic [31:0] C5 = 32'd523;

endpackage

// File: rtl/tone_sequencer_tick_gen.sv
// Duration-tick prescaler: one-cycle tick every DIV cycles, counting from the last clr.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tone_sequencer.sv
// Plays a register-held note table as freq/onOff for a downstream tone generator,
// with silent gaps between notes, optional looping and start/stop control.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int FCLK      = 50_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int NOTES     = 16,
  parameter int GAP_TICKS = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     wr_en,
  input  logic [$clog2(NOTES)-1:0] wr_addr,
  input  logic [31:0]              wr_freq,
  input  logic [15:0]              wr_dur,
  output logic [31:0]              freq,
  output logic                     onOff,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NOTES)-1:0] note_idx
);

  localparam int TICK_DIV = FCLK / TICK_HZ;
  localparam int AW       = $clog2(NOTES);

  note_t         table_q [NOTES];
  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   freq_q, freq_d;
  logic          onOff_q, onOff_d;
  logic [15:0]   dur_q, dur_d;

  logic          tick, restart, advance, doLoad, endOfSeq;
  logic [AW-1:0] nextIdx, loadIdx;
  note_t         loadNote;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .tick  (tick)
  );

  assign nextIdx  = idx_q + 1'b1;
  assign endOfSeq = (idx_q == AW'(NOTES - 1)) || (table_q[nextIdx].dur == 16'd0);

  // dur_q counts remaining ticks of the current PLAY or GAP; leaving on the
  // tick where it reads 1 makes each phase exactly N*TICK_DIV cycles long.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    freq_d   = freq_q;
    onOff_d  = onOff_q;
    dur_d    = dur_q;
    restart  = 1'b0;
    advance  = 1'b0;
    doLoad   = 1'b0;
    loadIdx  = idx_q;
    loadNote = '0;

    if (state_q != IDLE && stop) begin
      state_d = IDLE;
      onOff_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            doLoad  = 1'b1;
            loadIdx = '0;
          end
        end
        PLAY: begin
          if (tick) begin
            if (dur_q == 16'd1) begin
              if (GAP_TICKS != 0) begin
                state_d = GAP;
                onOff_d = 1'b0;
                dur_d   = 16'(GAP_TICKS);
                restart = 1'b1;
              end else begin
                advance = 1'b1;
              end
            end else begin
              dur_d = dur_q - 16'd1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (dur_q == 16'd1) advance = 1'b1;
            else                dur_d   = dur_q - 16'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (advance) begin
        if (!endOfSeq) begin
          doLoad  = 1'b1;
          loadIdx = nextIdx;
        end else if (loop_en) begin
          doLoad  = 1'b1;
          loadIdx = '0;
        end else begin
          state_d = DONE;
          onOff_d = 1'b0;
        end
      end

      // A zero-duration entry reached by a load ends the sequence silently.
      if (doLoad) begin
        loadNote = table_q[loadIdx];
        idx_d    = loadIdx;
        if (loadNote.dur == 16'd0) begin
          state_d = DONE;
          onOff_d = 1'b0;
        end else begin
          state_d = PLAY;
          freq_d  = loadNote.freq;
          onOff_d = (loadNote.freq != 32'd0);
          dur_d   = loadNote.dur;
          restart = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      freq_q  <= '0;
      onOff_q <= 1'b0;
      dur_q   <= '0;
      for (int i = 0; i < NOTES; i++) table_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      freq_q  <= freq_d;
      onOff_q <= onOff_d;
      dur_q   <= dur_d;
      if (wr_en) table_q[wr_addr] <= '{freq: wr_freq, dur: wr_dur};
    end
  end

  assign freq     = freq_q;
  assign onOff    = onOff_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign note_idx = idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICK_DIV=10, NOTES=4, GAP_TICKS=1.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, stop, loop_en, wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_freq;
  logic [15:0] wr_dur;
  logic [31:0] freq;
  logic        onOff, busy, done;
  logic [1:0]  note_idx;

  int compared   = 0;
  int mismatched = 0;

  tone_sequencer #(
    .FCLK      (1000),
    .TICK_HZ   (100),
    .NOTES     (4),
    .GAP_TICKS (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_freq  (wr_freq),
    .wr_dur   (wr_dur),
    .freq     (freq),
    .onOff    (onOff),
    .busy     (busy),
    .done     (done),
    .note_idx (note_idx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p);
    start = s;
    stop  = p;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic writeNote(input logic [1:0] a, input logic [31:0] f, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_freq = f;
    wr_dur  = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Checks n consecutive cycles of one PLAY or GAP phase, then leaves us at the next cycle.
  task automatic expectSegment(input string tag, input int n, input logic [31:0] f,
                               input logic on, input logic [1:0] idx);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, ".freq"},  freq,     f);
      checkOutput({tag, ".onOff"}, onOff,    on);
      checkOutput({tag, ".idx"},   note_idx, idx);
      checkOutput({tag, ".busy"},  busy,     1'b1);
      checkOutput({tag, ".done"},  done,     1'b0);
      @(negedge clk);
    end
  endtask

  task automatic expectDone(input string tag);
    checkOutput({tag, ".done"},  done,  1'b1);
    checkOutput({tag, ".busy"},  busy,  1'b1);
    checkOutput({tag, ".onOff"}, onOff, 1'b0);
    @(negedge clk);
    checkOutput({tag, ".doneAfter"}, done, 1'b0);
    checkOutput({tag, ".idle"},      busy, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_freq = '0;
    wr_dur  = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst.freq",  freq,     32'd0);
    checkOutput("rst.onOff", onOff,    1'b0);
    checkOutput("rst.busy",  busy,     1'b0);
    checkOutput("rst.done",  done,     1'b0);
    checkOutput("rst.idx",   note_idx, 2'd0);
    reset = 1'b0;

    writeNote(2'd0, 32'd440, 16'd3);
    writeNote(2'd1, 32'd0,   16'd2);
    writeNote(2'd2, 32'd262, 16'd1);
    writeNote(2'd3, 32'd999, 16'd0);

    // Basic playback with a rest and a terminator entry
    applyStimulus(1'b1, 1'b0);
    expectSegment("seq.n0",   30, 32'd440, 1'b1, 2'd0);
    expectSegment("seq.g0",   10, 32'd440, 1'b0, 2'd0);
    expectSegment("seq.n1",   20, 32'd0,   1'b0, 2'd1);
    expectSegment("seq.g1",   10, 32'd0,   1'b0, 2'd1);
    expectSegment("seq.n2",   10, 32'd262, 1'b1, 2'd2);
    expectSegment("seq.g2",   10, 32'd262, 1'b0, 2'd2);
    expectDone("seq.end");

    // Looping back to entry 0, then stop
    loop_en = 1'b1;
    applyStimulus(1'b1, 1'b0);
    expectSegment("loop.n0",  30, 32'd440, 1'b1, 2'd0);
    expectSegment("loop.g0",  10, 32'd440, 1'b0, 2'd0);
    expectSegment("loop.n1",  20, 32'd0,   1'b0, 2'd1);
    expectSegment("loop.g1",  10, 32'd0,   1'b0, 2'd1);
    expectSegment("loop.n2",  10, 32'd262, 1'b1, 2'd2);
    expectSegment("loop.g2",  10, 32'd262, 1'b0, 2'd2);
    expectSegment("loop.re0",  5, 32'd440, 1'b1, 2'd0);
    loop_en = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("loopStop.busy",  busy,  1'b0);
    checkOutput("loopStop.onOff", onOff, 1'b0);
    checkOutput("loopStop.done",  done,  1'b0);

    // Zero-duration first entry: immediate DONE
    writeNote(2'd0, 32'd440, 16'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("empty.idx", note_idx, 2'd0);
    expectDone("empty");
    checkOutput("empty.onOff", onOff, 1'b0);

    // Full table, no wrap-around without loop_en
    writeNote(2'd0, 32'd523, 16'd1);
    writeNote(2'd1, 32'd494, 16'd1);
    writeNote(2'd2, 32'd440, 16'd1);
    writeNote(2'd3, 32'd392, 16'd1);
    applyStimulus(1'b1, 1'b0);
    expectSegment("full.n0", 10, 32'd523, 1'b1, 2'd0);
    expectSegment("full.g0", 10, 32'd523, 1'b0, 2'd0);
    expectSegment("full.n1", 10, 32'd494, 1'b1, 2'd1);
    expectSegment("full.g1", 10, 32'd494, 1'b0, 2'd1);
    expectSegment("full.n2", 10, 32'd440, 1'b1, 2'd2);
    expectSegment("full.g2", 10, 32'd440, 1'b0, 2'd2);
    expectSegment("full.n3", 10, 32'd392, 1'b1, 2'd3);
    expectSegment("full.g3", 10, 32'd392, 1'b0, 2'd3);
    expectDone("full.end");
    for (int i = 0; i < 5; i++) begin
      checkOutput("full.noRepeat.done", done, 1'b0);
      checkOutput("full.noRepeat.busy", busy, 1'b0);
      @(negedge clk);
    end

    // start+stop together, start while busy, write to the playing entry
    applyStimulus(1'b1, 1'b1);
    checkOutput("startStop.busy",  busy,  1'b0);
    checkOutput("startStop.onOff", onOff, 1'b0);
    applyStimulus(1'b1, 1'b0);
    expectSegment("busy.n0a", 3, 32'd523, 1'b1, 2'd0);
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_freq = 32'd100;
    wr_dur  = 16'd5;
    expectSegment("busy.n0b", 1, 32'd523, 1'b1, 2'd0);
    start = 1'b0;
    wr_en = 1'b0;
    expectSegment("busy.n0c", 6,  32'd523, 1'b1, 2'd0);
    expectSegment("busy.g0",  10, 32'd523, 1'b0, 2'd0);
    expectSegment("busy.n1",  10, 32'd494, 1'b1, 2'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("busyStop.busy", busy, 1'b0);

    // Reset mid-PLAY clears outputs and the table
    applyStimulus(1'b1, 1'b0);
    expectSegment("rp.n0", 4, 32'd100, 1'b1, 2'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rp.freq",  freq,     32'd0);
    checkOutput("rp.onOff", onOff,    1'b0);
    checkOutput("rp.busy",  busy,     1'b0);
    checkOutput("rp.idx",   note_idx, 2'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rp.cleared.freq", freq, 32'd0);
    expectDone("rp.cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
